// File: rtl/wishbone_if.sv
// Classic Wishbone bus bundle, shared by a bus master and a register-mapped slave.
interface wishbone_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned GRANULARITY = 8
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULARITY;

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  stb;
  logic                  cyc;
  logic                  ack;

  modport master (output adr, dat_i, we, sel, stb, cyc, input dat_o, ack);
  modport slave  (input adr, dat_i, we, sel, stb, cyc, output dat_o, ack);
endinterface

// File: rtl/wb_stream_fifo.sv
// Wishbone-written FIFO drained by a valid/ready stream; STATUS and CTRL
// registers expose fill level, sticky overflow, flush and overflow clear.
module wb_stream_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned GRANULARITY = 8,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wishbone_if.slave             wb,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SEL_W = DATA_WIDTH / GRANULARITY;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "wb_stream_fifo: DEPTH must be a power of two and at least 2");
  end
  if (GRANULARITY != 8 && GRANULARITY != 16 && GRANULARITY != 32) begin : g_bad_gran
    $fatal(1, "wb_stream_fifo: GRANULARITY must be 8, 16 or 32");
  end
  if (DATA_WIDTH < 19 || (DATA_WIDTH % GRANULARITY) != 0) begin : g_bad_width
    $fatal(1, "wb_stream_fifo: DATA_WIDTH must hold STATUS and be a multiple of GRANULARITY");
  end
  if (ADDR_WIDTH < 4) begin : g_bad_addr
    $fatal(1, "wb_stream_fifo: ADDR_WIDTH must cover adr[3:2]");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rptr_q, wptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  ovf_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] dat_o_q;

  logic                  req_c, full_c, empty_c, full_sel_c;
  logic                  push_c, pop_c, ovf_set_c, flush_c, ovf_clr_c;
  reg_e                  reg_c;
  logic [DATA_WIDTH-1:0] status_c;
  logic                  unused_adr_c;

  // Request decode; fullness is judged on the pre-edge count.
  always_comb begin
    req_c      = wb.cyc & wb.stb & ~ack_q;
    reg_c      = reg_e'(wb.adr[3:2]);
    full_c     = (count_q == CNT_W'(DEPTH));
    empty_c    = (count_q == '0);
    full_sel_c = (wb.sel == {SEL_W{1'b1}});
    push_c     = 1'b0;
    ovf_set_c  = 1'b0;
    flush_c    = 1'b0;
    ovf_clr_c  = 1'b0;
    if (req_c && wb.we && reg_c == REG_DATA && full_sel_c) begin
      push_c    = ~full_c;
      ovf_set_c = full_c;
    end
    if (req_c && wb.we && reg_c == REG_CTRL) begin
      flush_c   = wb.dat_i[0];
      ovf_clr_c = wb.dat_i[1];
    end
    pop_c    = ~empty_c & m_ready_i;
    status_c = DATA_WIDTH'({ovf_q, full_c, empty_c, 16'(count_q)});
  end

  assign unused_adr_c = ^wb.adr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_o_q <= '0;
    end else begin
      ack_q <= req_c;
      if (req_c) begin
        dat_o_q <= (reg_c == REG_STATUS && !wb.we) ? status_c : '0;
      end
      if (ovf_set_c) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_c) begin
        ovf_q <= 1'b0;
      end
      // Flush wins over any pop landing on the same edge.
      if (flush_c) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_c) wptr_q <= wptr_q + PTR_W'(1);
        if (pop_c)  rptr_q <= rptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_c && !rst_i) begin
      mem[wptr_q] <= wb.dat_i;
    end
  end

  assign wb.ack    = ack_q;
  assign wb.dat_o  = dat_o_q;
  assign m_valid_o = ~empty_c;
  assign m_data_o  = mem[rptr_q];
endmodule

// File: tb/tb_wb_stream_fifo.sv
// Randomized bench for wb_stream_fifo against a queue-based model of the
// register map and stream behaviour.
module tb_wb_stream_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned GR    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  wishbone_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(GR)) wb_bus ();

  wb_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(GR), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb       (wb_bus),
    .m_data_o (m_data),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus overflow, ack and read-data state.
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_dat = '0;

  always @(posedge clk) begin : model
    logic req, do_pop, do_push, do_flush;
    int   pre;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ack = 1'b0;
      m_dat = '0;
    end else begin
      req      = wb_bus.cyc & wb_bus.stb & ~m_ack;
      pre      = mq.size();
      do_pop   = (pre != 0) && m_ready;
      do_push  = 1'b0;
      do_flush = 1'b0;
      if (req) begin
        m_dat = '0;
        case (wb_bus.adr[3:2])
          2'd0: if (wb_bus.we && wb_bus.sel == 4'hF) begin
                  if (pre == DEPTH) m_ovf = 1'b1;
                  else do_push = 1'b1;
                end
          2'd1: if (!wb_bus.we)
                  m_dat = {13'd0, m_ovf, pre == DEPTH, pre == 0, 16'(pre)};
          2'd2: if (wb_bus.we) begin
                  do_flush = wb_bus.dat_i[0];
                  if (wb_bus.dat_i[1]) m_ovf = 1'b0;
                end
          default: ;
        endcase
      end
      if (do_flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(wb_bus.dat_i);
      end
      m_ack = req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One bus access; rdy is held on the stream side only during the request cycle.
  task automatic bus_cycle(input logic [3:0] a, input logic [DW-1:0] d, input logic w,
                           input logic [3:0] s, input logic rdy,
                           output logic got_ack, output logic [DW-1:0] rd);
    wb_bus.adr   = AW'(a);
    wb_bus.dat_i = d;
    wb_bus.we    = w;
    wb_bus.sel   = s;
    wb_bus.cyc   = 1'b1;
    wb_bus.stb   = 1'b1;
    m_ready      = rdy;
    got_ack      = 1'b0;
    for (int i = 0; i < 4 && !got_ack; i++) begin
      tick();
      if (wb_bus.ack === 1'b1) got_ack = 1'b1;
    end
    rd         = wb_bus.dat_o;
    wb_bus.cyc = 1'b0;
    wb_bus.stb = 1'b0;
    wb_bus.we  = 1'b0;
    m_ready    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic ak;
    logic [DW-1:0] rd;
    do_reset();
    n_vec++;
    if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", m_valid); end
    n_vec++;
    if (wb_bus.ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %0b want 0", wb_bus.ack); end
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (!ak || rd !== 32'h0001_0000) begin
      n_err++; $display("FAIL reset_status ack %0b got %h want 00010000", ak, rd);
    end
    n_vec++;
    if (wb_bus.ack !== 1'b0) begin n_err++; $display("FAIL ack_pulse got %0b want 0", wb_bus.ack); end
  endtask

  task automatic test_single_push();
    logic ak;
    logic [DW-1:0] rd;
    bus_cycle(4'h0, 32'hA5A5_0001, 1'b1, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (!ak || m_valid !== 1'b1 || m_data !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL single_push ack %0b valid %0b data %h want 1 1 a5a50001", ak, m_valid, m_data);
    end
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (rd !== 32'h0000_0001 || rd !== m_dat) begin
      n_err++; $display("FAIL single_status got %h want 00000001 model %h", rd, m_dat);
    end
  endtask

  task automatic test_overflow();
    logic ak;
    logic [DW-1:0] rd;
    do_reset();
    for (int i = 1; i <= 17; i++) bus_cycle(4'h0, DW'(i), 1'b1, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (!ak) begin n_err++; $display("FAIL overflow_ack got 0 want 1"); end
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (rd !== 32'h0006_0010 || rd !== m_dat) begin
      n_err++; $display("FAIL full_status got %h want 00060010 model %h", rd, m_dat);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== DW'(i)) begin
        n_err++; $display("FAIL drain_%0d valid %0b data %h want 1 %h", i, m_valid, m_data, DW'(i));
      end
      tick();
    end
    m_ready = 1'b0;
    n_vec++;
    if (m_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty valid %0b want 0", m_valid); end
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (rd !== 32'h0005_0000 || rd !== m_dat) begin
      n_err++; $display("FAIL sticky_ovf got %h want 00050000 model %h", rd, m_dat);
    end
  endtask

  task automatic test_back_to_back();
    logic ak;
    logic [DW-1:0] rd;
    int guard;
    do_reset();
    for (int i = 0; i < 3; i++) bus_cycle(4'h0, $urandom, 1'b1, 4'hF, 1'b0, ak, rd);
    bus_cycle(4'h0, $urandom, 1'b1, 4'hF, 1'b1, ak, rd);
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (rd !== 32'h0000_0003 || rd !== m_dat) begin
      n_err++; $display("FAIL push_pop_count got %h want 00000003 model %h", rd, m_dat);
    end
    for (int i = 0; i < 40; i++) begin
      bus_cycle(4'h0, $urandom, 1'b1, 4'hF, 1'b1, ak, rd);
      n_vec++;
      if (!ak || m_valid !== 1'b1 || m_data !== mq[0]) begin
        n_err++; $display("FAIL wrap_%0d ack %0b valid %0b data %h want %h", i, ak, m_valid, m_data, mq[0]);
      end
    end
    guard = 0;
    m_ready = 1'b1;
    while (mq.size() != 0 && guard < 64) begin
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== mq[0]) begin
        n_err++; $display("FAIL wrap_drain valid %0b data %h want %h", m_valid, m_data, mq[0]);
      end
      tick();
      guard++;
    end
    m_ready = 1'b0;
    n_vec++;
    if (guard != 3 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_tail drained %0d valid %0b want 3 0", guard, m_valid);
    end
  endtask

  task automatic test_partial_and_flush();
    logic ak;
    logic [DW-1:0] rd;
    do_reset();
    for (int i = 0; i < 17; i++) bus_cycle(4'h0, $urandom, 1'b1, 4'hF, 1'b0, ak, rd);
    m_ready = 1'b1;
    repeat (11) tick();
    m_ready = 1'b0;
    bus_cycle(4'h0, 32'hDEAD_BEEF, 1'b1, 4'b0011, 1'b0, ak, rd);
    n_vec++;
    if (!ak) begin n_err++; $display("FAIL partial_ack got 0 want 1"); end
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (rd !== 32'h0004_0005 || rd !== m_dat) begin
      n_err++; $display("FAIL partial_status got %h want 00040005 model %h", rd, m_dat);
    end
    bus_cycle(4'h8, 32'h3, 1'b1, 4'hF, 1'b1, ak, rd);
    n_vec++;
    if (!ak || m_valid !== 1'b0) begin
      n_err++; $display("FAIL flush ack %0b valid %0b want 1 0", ak, m_valid);
    end
    bus_cycle(4'h4, '0, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (rd !== 32'h0001_0000 || rd !== m_dat) begin
      n_err++; $display("FAIL flush_status got %h want 00010000 model %h", rd, m_dat);
    end
    bus_cycle(4'hC, $urandom, 1'b0, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (!ak || rd !== 32'h0) begin
      n_err++; $display("FAIL reserved_read ack %0b got %h want 1 0", ak, rd);
    end
  endtask

  task automatic test_reset_abort();
    logic ak;
    logic [DW-1:0] rd;
    for (int i = 0; i < 2; i++) bus_cycle(4'h0, $urandom, 1'b1, 4'hF, 1'b0, ak, rd);
    wb_bus.adr   = AW'(0);
    wb_bus.dat_i = 32'h1234_5678;
    wb_bus.we    = 1'b1;
    wb_bus.sel   = 4'hF;
    wb_bus.cyc   = 1'b1;
    wb_bus.stb   = 1'b1;
    rst          = 1'b1;
    tick();
    n_vec++;
    if (wb_bus.ack !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL abort ack %0b valid %0b want 0 0", wb_bus.ack, m_valid);
    end
    rst        = 1'b0;
    wb_bus.cyc = 1'b0;
    wb_bus.stb = 1'b0;
    wb_bus.we  = 1'b0;
    tick();
    n_vec++;
    if (wb_bus.ack !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_idle ack %0b valid %0b want 0 0", wb_bus.ack, m_valid);
    end
    bus_cycle(4'h0, 32'hBEEF_0042, 1'b1, 4'hF, 1'b0, ak, rd);
    n_vec++;
    if (!ak || m_valid !== 1'b1 || m_data !== 32'hBEEF_0042 || mq.size() != 1) begin
      n_err++; $display("FAIL reissue ack %0b valid %0b data %h want 1 1 beef0042", ak, m_valid, m_data);
    end
  endtask

  initial begin
    wb_bus.adr   = '0;
    wb_bus.dat_i = '0;
    wb_bus.we    = 1'b0;
    wb_bus.sel   = '0;
    wb_bus.cyc   = 1'b0;
    wb_bus.stb   = 1'b0;
    test_reset();
    test_single_push();
    test_overflow();
    test_back_to_back();
    test_partial_and_flush();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
